// File: rtl/wdt_pkg.sv
// Shared types and helpers for the two-stage watchdog timer.
package wdt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_WARN    = 2'd2,
    ST_EXPIRED = 2'd3
  } wdt_state_e;

  localparam logic [7:0] WARN_CNT_MAX = 8'hFF;

  // Saturating increment for the WARN-entry counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == WARN_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wdt_prescaler.sv
// Divides clk down to watchdog ticks; only counts while the watchdog is armed.
module wdt_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  // Free-running divider, restarted on kick or whenever the watchdog is not armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (clr || !run || (pcnt == LAST)) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign tick = run && (pcnt == LAST);

endmodule

// File: rtl/wdt_watchdog_timer.sv
// Two-stage watchdog: timeout raises warn_irq, an unserviced grace window raises a sticky wdt_rst_req.
module wdt_watchdog_timer
  import wdt_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int PRESCALE    = 1,
  parameter int DEF_TIMEOUT = 1000,
  parameter int GRACE       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic             kick,
  input  logic             irq_clr,
  output logic [CNT_W-1:0] count_o,
  output logic [1:0]       state_o,
  output logic             warn_irq,
  output logic             wdt_rst_req,
  output logic [7:0]       warn_cnt
);

  localparam logic [CNT_W-1:0] DEF_T   = CNT_W'(DEF_TIMEOUT);
  localparam logic [CNT_W-1:0] GRACE_V = CNT_W'(GRACE);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  wdt_state_e       state;
  logic [CNT_W-1:0] timeout_reg;
  logic             run;
  logic             kick_ok;
  logic             tick;

  assign run     = (state == ST_RUN) || (state == ST_WARN);
  assign kick_ok = en && kick && run;
  assign state_o = state;

  wdt_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clr  (kick_ok),
    .tick (tick)
  );

  // Watchdog FSM, down-counter, timeout register and sticky status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      count_o     <= '0;
      timeout_reg <= DEF_T;
      warn_irq    <= 1'b0;
      wdt_rst_req <= 1'b0;
      warn_cnt    <= 8'd0;
    end else begin
      if (cfg_we) begin
        timeout_reg <= (cfg_timeout == '0) ? ONE : cfg_timeout;
      end
      // Clear first so a same-cycle WARN entry below wins.
      if (irq_clr) begin
        warn_irq <= 1'b0;
      end
      if (!en) begin
        state   <= ST_IDLE;
        count_o <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_RUN;
            count_o <= timeout_reg;
          end
          ST_RUN: begin
            if (kick) begin
              count_o <= timeout_reg;
            end else if (tick) begin
              if (count_o > ONE) begin
                count_o <= count_o - ONE;
              end else begin
                state    <= ST_WARN;
                count_o  <= GRACE_V;
                warn_irq <= 1'b1;
                warn_cnt <= sat_inc8(warn_cnt);
              end
            end
          end
          ST_WARN: begin
            if (kick) begin
              state   <= ST_RUN;
              count_o <= timeout_reg;
            end else if (tick) begin
              if (count_o > ONE) begin
                count_o <= count_o - ONE;
              end else begin
                state       <= ST_EXPIRED;
                count_o     <= '0;
                wdt_rst_req <= 1'b1;
              end
            end
          end
          ST_EXPIRED: begin
            state <= ST_EXPIRED;
          end
          default: begin
            state   <= ST_IDLE;
            count_o <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wdt_watchdog_timer.sv
// Directed bench for wdt_watchdog_timer with a cycle model checked every falling edge.
module tb_wdt_watchdog_timer;

  localparam int GRACE_T = 4;
  localparam int DEF_T   = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cfg_we = 1'b0;
  logic [31:0] cfg_timeout = 32'd0;
  logic        kick = 1'b0;
  logic        irq_clr = 1'b0;
  logic [31:0] count_o;
  logic [1:0]  state_o;
  logic        warn_irq;
  logic        wdt_rst_req;
  logic [7:0]  warn_cnt;

  int n_checks = 0;
  int n_err = 0;

  wdt_watchdog_timer #(
    .CNT_W(32), .PRESCALE(1), .DEF_TIMEOUT(DEF_T), .GRACE(GRACE_T)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_timeout(cfg_timeout),
    .kick(kick), .irq_clr(irq_clr), .count_o(count_o), .state_o(state_o),
    .warn_irq(warn_irq), .wdt_rst_req(wdt_rst_req), .warn_cnt(warn_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0..3 plus remaining ticks; one tick per cycle when armed.
  int     m_st = 0;
  longint m_cnt = 0;
  longint m_tmo = DEF_T;
  int     m_irq = 0;
  int     m_req = 0;
  int     m_wcnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 0; m_cnt <= 0; m_tmo <= DEF_T; m_irq <= 0; m_req <= 0; m_wcnt <= 0;
    end else begin
      if (cfg_we) m_tmo <= (cfg_timeout == 32'd0) ? 1 : longint'(cfg_timeout);
      if (irq_clr) m_irq <= 0;
      if (!en) begin
        m_st <= 0; m_cnt <= 0;
      end else if (m_st == 0) begin
        m_st <= 1; m_cnt <= m_tmo;
      end else if (m_st != 3) begin
        if (kick) begin
          m_st <= 1; m_cnt <= m_tmo;
        end else if (m_cnt > 1) begin
          m_cnt <= m_cnt - 1;
        end else if (m_st == 1) begin
          m_st <= 2; m_cnt <= GRACE_T; m_irq <= 1;
          m_wcnt <= (m_wcnt < 255) ? m_wcnt + 1 : 255;
        end else begin
          m_st <= 3; m_cnt <= 0; m_req <= 1;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    n_checks++;
    if (state_o !== 2'(m_st) || count_o !== 32'(m_cnt) || warn_irq !== 1'(m_irq) ||
        wdt_rst_req !== 1'(m_req) || warn_cnt !== 8'(m_wcnt)) begin
      n_err++;
      $display("FAIL model_cmp t=%0t: got st=%0d cnt=%0d irq=%0b req=%0b wc=%0d expected st=%0d cnt=%0d irq=%0d req=%0d wc=%0d",
               $time, state_o, count_o, warn_irq, wdt_rst_req, warn_cnt, m_st, m_cnt, m_irq, m_req, m_wcnt);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset state, then configure 10 and enable
    cyc();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_count", count_o, 32'd0);
    chk("rst_irq", 32'(warn_irq), 32'd0);
    chk("rst_req", 32'(wdt_rst_req), 32'd0);
    chk("rst_wcnt", 32'(warn_cnt), 32'd0);
    rst = 1'b0; cfg_we = 1'b1; cfg_timeout = 32'd10;
    cyc();
    cfg_we = 1'b0; en = 1'b1;
    cyc();
    chk("run_entry_state", 32'(state_o), 32'd1);
    chk("run_entry_count", count_o, 32'd10);
    cyc();
    chk("first_dec", count_o, 32'd9);

    // 2. periodic kicks keep it in RUN
    for (int i = 0; i < 20; i++) begin
      kick = 1'b1; cyc(); kick = 1'b0;
      chk("kick_reload", count_o, 32'd10);
      for (int j = 0; j < 4; j++) begin
        cyc();
        chk("kick_floor", 32'(count_o >= 32'd5), 32'd1);
        chk("kick_state", 32'(state_o), 32'd1);
      end
    end
    chk("kick_no_irq", 32'(warn_irq), 32'd0);

    // 3. no kick: WARN after 10, EXPIRED after 4 more
    kick = 1'b1; cyc(); kick = 1'b0;
    repeat (9) cyc();
    chk("pre_warn_count", count_o, 32'd1);
    cyc();
    chk("warn_state", 32'(state_o), 32'd2);
    chk("warn_count", count_o, 32'd4);
    chk("warn_irq", 32'(warn_irq), 32'd1);
    chk("warn_cnt1", 32'(warn_cnt), 32'd1);
    repeat (4) cyc();
    chk("exp_state", 32'(state_o), 32'd3);
    chk("exp_count", count_o, 32'd0);
    chk("exp_req", 32'(wdt_rst_req), 32'd1);
    kick = 1'b1; cyc(); kick = 1'b0;
    chk("exp_kick_ignored", 32'(state_o), 32'd3);

    // 4. re-enable, irq_clr behaviour, kick in WARN
    en = 1'b0; cyc();
    chk("dis_state", 32'(state_o), 32'd0);
    chk("dis_req_kept", 32'(wdt_rst_req), 32'd1);
    en = 1'b1; cyc();
    chk("reen_count", count_o, 32'd10);
    chk("reen_req", 32'(wdt_rst_req), 32'd1);
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
    chk("irq_clr", 32'(warn_irq), 32'd0);
    repeat (8) cyc();
    chk("pre_warn2", count_o, 32'd1);
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
    chk("set_wins", 32'(warn_irq), 32'd1);
    chk("warn_cnt2", 32'(warn_cnt), 32'd2);
    repeat (2) cyc();
    chk("warn_cnt_down", count_o, 32'd2);
    kick = 1'b1; cyc(); kick = 1'b0;
    chk("warn_kick_state", 32'(state_o), 32'd1);
    chk("warn_kick_count", count_o, 32'd10);
    chk("warn_kick_irq", 32'(warn_irq), 32'd1);

    // 5. en=0 beats kick; cfg_we applies at next reload; 0 -> 1
    cyc();
    en = 1'b0; kick = 1'b1; cyc(); kick = 1'b0;
    chk("en_prio_state", 32'(state_o), 32'd0);
    chk("en_prio_count", count_o, 32'd0);
    en = 1'b1; cyc();
    cfg_we = 1'b1; cfg_timeout = 32'd3; cyc(); cfg_we = 1'b0;
    chk("cfg_inflight", count_o, 32'd9);
    kick = 1'b1; cyc(); kick = 1'b0;
    chk("cfg_reload3", count_o, 32'd3);
    cfg_we = 1'b1; cfg_timeout = 32'd0; cyc(); cfg_we = 1'b0;
    kick = 1'b1; cyc(); kick = 1'b0;
    chk("cfg_zero_is_one", count_o, 32'd1);
    cyc();
    chk("warn_cnt3", 32'(warn_cnt), 32'd3);

    // 6. saturate warn_cnt, then async reset mid-WARN
    for (int i = 0; i < 260; i++) begin
      kick = 1'b1; cyc(); kick = 1'b0; cyc();
    end
    chk("warn_cnt_sat", 32'(warn_cnt), 32'd255);
    cyc();
    chk("mid_warn", 32'(state_o), 32'd2);
    #3 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_count", count_o, 32'd0);
    chk("arst_flags", 32'({warn_irq, wdt_rst_req}), 32'd0);
    chk("arst_wcnt", 32'(warn_cnt), 32'd0);
    #9 rst = 1'b0; en = 1'b0; kick = 1'b1;
    cyc(); kick = 1'b0;
    chk("idle_kick", 32'(state_o), 32'd0);
    en = 1'b1; cyc();
    chk("def_timeout", count_o, 32'(DEF_T));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
